instr_fetcher: RTL and testbench

//   Per-core instruction fetch stage. Sits directly downstream of pc: takes its updated_pc as current_pc.

---
 rtl/gpu_pkg.sv | 21 ++
 rtl/fetch_hit_buffer.sv | 41 ++++
 rtl/instr_fetcher.sv | 135 +++++++++++++
 tb/tb_instr_fetcher.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared encodings for the core FSM and the instruction fetch stage.
// Used by pc, instr_fetcher and decoder so all agree on state values.
package gpu_pkg;

    localparam logic [2:0] CORE_IDLE    = 3'b000;
    localparam logic [2:0] CORE_FETCH   = 3'b001;
    localparam logic [2:0] CORE_DECODE  = 3'b010;
    localparam logic [2:0] CORE_REQUEST = 3'b011;
    localparam logic [2:0] CORE_WAIT    = 3'b100;
    localparam logic [2:0] CORE_EXECUTE = 3'b101;
    localparam logic [2:0] CORE_UPDATE  = 3'b110;
    localparam logic [2:0] CORE_DONE    = 3'b111;

    typedef enum logic [2:0] {
        FS_IDLE     = 3'b000,
        FS_FETCHING = 3'b001,
        FS_FETCHED  = 3'b010,
        FS_ERROR    = 3'b011
    } fetcher_state_t;

endpackage

// File: rtl/fetch_hit_buffer.sv
// Single-entry tag/data buffer remembering the last word returned by memory.
// Lookup is combinational so a hit can complete in the same cycle as FETCH.
module fetch_hit_buffer #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_tag,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic [ADDR_BITS-1:0] lookup_tag,
    output logic                 hit,
    output logic [DATA_BITS-1:0] rd_data
);

    logic                 valid_q;
    logic [ADDR_BITS-1:0] tag_q;
    logic [DATA_BITS-1:0] data_q;

    // NOTE: only the valid bit needs reset; tag/data are never used while it is
    // clear, so they live in a reset-free process and stay plain flops.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= 1'b0;
        end else if (wr_en) begin
            valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q  <= wr_tag;
            data_q <= wr_data;
        end
    end

    assign hit     = valid_q && (tag_q == lookup_tag);
    assign rd_data = data_q;

endmodule

// File: rtl/instr_fetcher.sv
// Instruction fetch stage: valid/ready read of program memory, single-entry
// hit buffer for repeated PCs, and a sticky watchdog for a silent memory.
module instr_fetcher
    import gpu_pkg::*;
#(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int TIMEOUT_CYCLES        = 64
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic                             fetch_timeout
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

    fetcher_state_t                   state_q, state_d;
    logic                             valid_q, valid_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [PROGRAM_MEM_DATA_BITS-1:0] instr_q, instr_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d, cnt_inc;
    logic                             timeout_q, timeout_d;

    logic                             buf_hit;
    logic                             buf_wr;
    logic [PROGRAM_MEM_DATA_BITS-1:0] buf_data;

    fetch_hit_buffer #(
        .ADDR_BITS (PROGRAM_MEM_ADDR_BITS),
        .DATA_BITS (PROGRAM_MEM_DATA_BITS)
    ) u_hit_buffer (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (buf_wr),
        .wr_tag     (addr_q),
        .wr_data    (mem_read_data),
        .lookup_tag (current_pc),
        .hit        (buf_hit),
        .rd_data    (buf_data)
    );

    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    // NOTE: every output of this block gets a default first, so no branch can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        addr_d    = addr_q;
        instr_d   = instr_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        buf_wr    = 1'b0;

        unique case (state_q)
            FS_IDLE: begin
                if (core_state == CORE_FETCH) begin
                    if (buf_hit) begin
                        instr_d = buf_data;
                        state_d = FS_FETCHED;
                    end else begin
                        valid_d = 1'b1;
                        addr_d  = current_pc;
                        cnt_d   = '0;
                        state_d = FS_FETCHING;
                    end
                end
            end
            FS_FETCHING: begin
                // A response always beats the watchdog firing in the same cycle.
                if (mem_read_ready) begin
                    instr_d = mem_read_data;
                    buf_wr  = 1'b1;
                    valid_d = 1'b0;
                    state_d = FS_FETCHED;
                end else begin
                    cnt_d = cnt_inc;
                    if (TIMEOUT_CYCLES != 0 && cnt_inc == TIMEOUT_LIM) begin
                        valid_d   = 1'b0;
                        timeout_d = 1'b1;
                        state_d   = FS_ERROR;
                    end
                end
            end
            FS_FETCHED: begin
                if (core_state == CORE_DECODE) begin
                    state_d = FS_IDLE;
                end
            end
            FS_ERROR: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = FS_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= FS_IDLE;
            valid_q   <= 1'b0;
            addr_q    <= '0;
            instr_q   <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            addr_q    <= addr_d;
            instr_q   <= instr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign mem_read_valid   = valid_q;
    assign mem_read_address = addr_q;
    assign fetcher_state    = state_q;
    assign instruction      = instr_q;
    assign fetch_timeout    = timeout_q;

endmodule

// File: tb/tb_instr_fetcher.sv
// Directed bench for instr_fetcher with a 4-cycle watchdog; inputs are driven
// and outputs sampled 1ns after each rising edge.
module tb_instr_fetcher;
    import gpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  core_state;
    logic [7:0]  current_pc;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;
    logic [2:0]  fetcher_state;
    logic [15:0] instruction;
    logic        fetch_timeout;

    int errors = 0;
    int checks = 0;

    localparam logic [2:0] S_IDLE     = 3'b000;
    localparam logic [2:0] S_FETCHING = 3'b001;
    localparam logic [2:0] S_FETCHED  = 3'b010;
    localparam logic [2:0] S_ERROR    = 3'b011;

    instr_fetcher #(
        .PROGRAM_MEM_ADDR_BITS (8),
        .PROGRAM_MEM_DATA_BITS (16),
        .TIMEOUT_CYCLES        (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .core_state       (core_state),
        .current_pc       (current_pc),
        .mem_read_valid   (mem_read_valid),
        .mem_read_address (mem_read_address),
        .mem_read_ready   (mem_read_ready),
        .mem_read_data    (mem_read_data),
        .fetcher_state    (fetcher_state),
        .instruction      (instruction),
        .fetch_timeout    (fetch_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; core_state = CORE_IDLE; current_pc = 8'd0;
        mem_read_ready = 1'b0; mem_read_data = 16'h0;
        tick(); tick();
        checks++; if (mem_read_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", mem_read_valid); end
        checks++; if (mem_read_address !== 8'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", mem_read_address); end
        checks++; if (instruction !== 16'h0) begin errors++; $display("FAIL reset_instr: got %h want 0000", instruction); end
        checks++; if (fetcher_state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %b want 000", fetcher_state); end
        checks++; if (fetch_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %0b want 0", fetch_timeout); end
        reset = 1'b1;
    endtask

    task automatic test_miss();
        current_pc = 8'd20; core_state = CORE_FETCH;
        tick();
        checks++; if (mem_read_valid !== 1'b1) begin errors++; $display("FAIL miss_valid: got %0b want 1", mem_read_valid); end
        checks++; if (mem_read_address !== 8'd20) begin errors++; $display("FAIL miss_addr: got %0d want 20", mem_read_address); end
        checks++; if (fetcher_state !== S_FETCHING) begin errors++; $display("FAIL miss_state: got %b want 001", fetcher_state); end
        core_state = CORE_IDLE;
        tick(); tick();
        checks++; if (mem_read_valid !== 1'b1) begin errors++; $display("FAIL miss_wait_valid: got %0b want 1", mem_read_valid); end
        mem_read_ready = 1'b1; mem_read_data = 16'hA5C3;
        tick();
        mem_read_ready = 1'b0;
        checks++; if (instruction !== 16'hA5C3) begin errors++; $display("FAIL miss_instr: got %h want a5c3", instruction); end
        checks++; if (fetcher_state !== S_FETCHED) begin errors++; $display("FAIL miss_done_state: got %b want 010", fetcher_state); end
        checks++; if (mem_read_valid !== 1'b0) begin errors++; $display("FAIL miss_done_valid: got %0b want 0", mem_read_valid); end
        core_state = CORE_FETCH;
        tick();
        checks++; if (fetcher_state !== S_FETCHED || mem_read_valid !== 1'b0) begin errors++; $display("FAIL fetched_no_refetch: got state %b valid %0b want 010 0", fetcher_state, mem_read_valid); end
        core_state = CORE_DECODE;
        tick();
        checks++; if (fetcher_state !== S_IDLE) begin errors++; $display("FAIL miss_decode: got %b want 000", fetcher_state); end
    endtask

    task automatic test_hit();
        current_pc = 8'd20; core_state = CORE_FETCH;
        tick();
        checks++; if (fetcher_state !== S_FETCHED) begin errors++; $display("FAIL hit_state: got %b want 010", fetcher_state); end
        checks++; if (instruction !== 16'hA5C3) begin errors++; $display("FAIL hit_instr: got %h want a5c3", instruction); end
        checks++; if (mem_read_valid !== 1'b0) begin errors++; $display("FAIL hit_valid: got %0b want 0", mem_read_valid); end
        core_state = CORE_DECODE;
        tick();
        current_pc = 8'd32; core_state = CORE_FETCH;
        tick();
        checks++; if (mem_read_valid !== 1'b1 || mem_read_address !== 8'd32) begin errors++; $display("FAIL hit_then_miss: got valid %0b addr %0d want 1 32", mem_read_valid, mem_read_address); end
        core_state = CORE_IDLE; mem_read_ready = 1'b1; mem_read_data = 16'h1234;
        tick();
        mem_read_ready = 1'b0;
        checks++; if (instruction !== 16'h1234) begin errors++; $display("FAIL miss32_instr: got %h want 1234", instruction); end
        core_state = CORE_DECODE;
        tick();
    endtask

    task automatic test_ready_on_limit();
        current_pc = 8'd50; core_state = CORE_FETCH;
        tick();
        core_state = CORE_IDLE;
        tick(); tick(); tick();
        checks++; if (fetcher_state !== S_FETCHING) begin errors++; $display("FAIL limit_wait_state: got %b want 001", fetcher_state); end
        mem_read_ready = 1'b1; mem_read_data = 16'hBEEF;
        tick();
        mem_read_ready = 1'b0;
        checks++; if (fetcher_state !== S_FETCHED) begin errors++; $display("FAIL limit_state: got %b want 010", fetcher_state); end
        checks++; if (fetch_timeout !== 1'b0) begin errors++; $display("FAIL limit_timeout: got %0b want 0", fetch_timeout); end
        checks++; if (instruction !== 16'hBEEF) begin errors++; $display("FAIL limit_instr: got %h want beef", instruction); end
        core_state = CORE_DECODE;
        tick();
    endtask

    task automatic test_timeout();
        current_pc = 8'd60; core_state = CORE_FETCH;
        tick();
        core_state = CORE_IDLE;
        tick(); tick(); tick();
        checks++; if (fetcher_state !== S_FETCHING || mem_read_valid !== 1'b1) begin errors++; $display("FAIL timeout_pre: got state %b valid %0b want 001 1", fetcher_state, mem_read_valid); end
        tick();
        checks++; if (fetcher_state !== S_ERROR) begin errors++; $display("FAIL timeout_state: got %b want 011", fetcher_state); end
        checks++; if (fetch_timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %0b want 1", fetch_timeout); end
        checks++; if (mem_read_valid !== 1'b0) begin errors++; $display("FAIL timeout_valid: got %0b want 0", mem_read_valid); end
        mem_read_ready = 1'b1; mem_read_data = 16'hDEAD;
        tick();
        mem_read_ready = 1'b0; core_state = CORE_FETCH;
        tick();
        checks++; if (fetcher_state !== S_ERROR || fetch_timeout !== 1'b1) begin errors++; $display("FAIL error_absorb: got state %b flag %0b want 011 1", fetcher_state, fetch_timeout); end
        checks++; if (instruction !== 16'hBEEF) begin errors++; $display("FAIL error_instr: got %h want beef", instruction); end
        core_state = CORE_IDLE;
    endtask

    task automatic test_reset_mid_fetch();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++; if (fetcher_state !== S_IDLE || fetch_timeout !== 1'b0) begin errors++; $display("FAIL error_reset: got state %b flag %0b want 000 0", fetcher_state, fetch_timeout); end
        current_pc = 8'd12; core_state = CORE_FETCH;
        tick();
        core_state = CORE_IDLE;
        checks++; if (mem_read_address !== 8'd12 || mem_read_valid !== 1'b1) begin errors++; $display("FAIL rmf_issue: got addr %0d valid %0b want 12 1", mem_read_address, mem_read_valid); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++; if (fetcher_state !== S_IDLE || mem_read_valid !== 1'b0) begin errors++; $display("FAIL rmf_state: got state %b valid %0b want 000 0", fetcher_state, mem_read_valid); end
        mem_read_ready = 1'b1; mem_read_data = 16'h7777;
        tick();
        mem_read_ready = 1'b0;
        checks++; if (instruction !== 16'h0 || fetcher_state !== S_IDLE) begin errors++; $display("FAIL rmf_late_ready: got instr %h state %b want 0000 000", instruction, fetcher_state); end
        current_pc = 8'd50; core_state = CORE_FETCH;
        tick();
        checks++; if (fetcher_state !== S_FETCHING || mem_read_valid !== 1'b1) begin errors++; $display("FAIL rmf_buf_invalid: got state %b valid %0b want 001 1", fetcher_state, mem_read_valid); end
        mem_read_ready = 1'b1; mem_read_data = 16'h5050; core_state = CORE_IDLE;
        tick();
        mem_read_ready = 1'b0; core_state = CORE_DECODE;
        tick();
    endtask

    task automatic test_stability();
        current_pc = 8'd12; core_state = CORE_FETCH;
        tick();
        current_pc = 8'd40;
        tick();
        checks++; if (mem_read_address !== 8'd12) begin errors++; $display("FAIL stable_addr1: got %0d want 12", mem_read_address); end
        current_pc = 8'd12;
        tick();
        current_pc = 8'd40;
        checks++; if (mem_read_address !== 8'd12 || mem_read_valid !== 1'b1) begin errors++; $display("FAIL stable_addr2: got addr %0d valid %0b want 12 1", mem_read_address, mem_read_valid); end
        mem_read_ready = 1'b1; mem_read_data = 16'h0C0C;
        tick();
        mem_read_ready = 1'b0;
        checks++; if (instruction !== 16'h0C0C) begin errors++; $display("FAIL stable_instr: got %h want 0c0c", instruction); end
        core_state = CORE_DECODE;
        tick();
        core_state = CORE_IDLE; mem_read_ready = 1'b1; mem_read_data = 16'hFFFF;
        tick();
        mem_read_ready = 1'b0;
        checks++; if (fetcher_state !== S_IDLE || instruction !== 16'h0C0C || mem_read_valid !== 1'b0) begin errors++; $display("FAIL idle_ready: got state %b instr %h valid %0b want 000 0c0c 0", fetcher_state, instruction, mem_read_valid); end
        current_pc = 8'd12; core_state = CORE_FETCH;
        tick();
        checks++; if (fetcher_state !== S_FETCHED || instruction !== 16'h0C0C || mem_read_valid !== 1'b0) begin errors++; $display("FAIL stable_hit: got state %b instr %h valid %0b want 010 0c0c 0", fetcher_state, instruction, mem_read_valid); end
        core_state = CORE_IDLE;
    endtask

    initial begin
        #1;
        test_reset();
        test_miss();
        test_hit();
        test_ready_on_limit();
        test_timeout();
        test_reset_mid_fetch();
        test_stability();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
